// File: rtl/wb_regfile_pkg.sv
// Shared configuration for the write-back register file and its scoreboard.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-to-read forwarding).
package wb_regfile_pkg;

    localparam int XLEN          = 32;
    localparam int REG_ADDRWIDTH = 5;
    localparam int REG_NUM       = 2 ** REG_ADDRWIDTH;
    localparam int PEND_W        = 2;

    localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        TRUE       = 1'b1;
    localparam logic        FALSE      = 1'b0;

`ifdef WB_BYPASS_EN
    localparam logic BYPASS_ON = TRUE;
`else
    localparam logic BYPASS_ON = FALSE;
`endif

    typedef logic [REG_ADDRWIDTH-1:0] reg_addr_t;
    typedef logic [PEND_W-1:0]        pend_t;

    localparam reg_addr_t X0       = '0;
    localparam pend_t     PEND_ONE = pend_t'(1);
    localparam pend_t     PEND_MAX = '1;

    // True when an enabled write-back targets a real (non-x0) register equal to addr.
    function automatic logic wb_hits(input logic en, input reg_addr_t wb_addr,
                                     input reg_addr_t addr);
        return en && (wb_addr == addr) && (addr != X0);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters and the ID-stage stall request.
// The resolve term is active only when WB_BYPASS_EN is defined.
module wb_scoreboard
    import wb_regfile_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [REG_ADDRWIDTH-1:0] wb_addr,
    input  logic                     issue_en,
    input  logic [REG_ADDRWIDTH-1:0] issue_rd_addr,
    input  logic                     rs1_en,
    input  logic [REG_ADDRWIDTH-1:0] rs1_addr,
    input  logic                     rs2_en,
    input  logic [REG_ADDRWIDTH-1:0] rs2_addr,
    output logic                     stall_req
);

    pend_t              pend [REG_NUM];
    pend_t              pend_rs1;
    pend_t              pend_rs2;
    pend_t              pend_rd;
    logic               resolve1;
    logic               resolve2;
    logic               rs1_block;
    logic               rs2_block;
    logic               full_block;
    logic               issue_ok;
    logic [REG_NUM-1:0] inc_vec;
    logic [REG_NUM-1:0] dec_vec;

    // A source is released early only when this write-back retires its last pending write.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
        stall_req = FALSE;
        pend_rs1  = pend[rs1_addr];
        pend_rs2  = pend[rs2_addr];
        pend_rd   = pend[issue_rd_addr];

        resolve1  = BYPASS_ON && wb_hits(wb_en, wb_addr, rs1_addr) && (pend_rs1 == PEND_ONE);
        resolve2  = BYPASS_ON && wb_hits(wb_en, wb_addr, rs2_addr) && (pend_rs2 == PEND_ONE);

        rs1_block = rs1_en && (rs1_addr != X0) && (pend_rs1 != '0) && !resolve1;
        rs2_block = rs2_en && (rs2_addr != X0) && (pend_rs2 != '0) && !resolve2;
        full_block = issue_en && (issue_rd_addr != X0) && (pend_rd == PEND_MAX)
                   && !(wb_en && (wb_addr == issue_rd_addr));

        if (rs1_block || rs2_block || full_block) begin
            stall_req = TRUE;
        end
        issue_ok = issue_en && !stall_req && (issue_rd_addr != X0);
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            inc_vec[i] = issue_ok && (issue_rd_addr == reg_addr_t'(i));
            dec_vec[i] = wb_hits(wb_en, wb_addr, reg_addr_t'(i));
        end
    end

    // Entry 0 never sees inc or dec, so it holds its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                pend[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < REG_NUM; i++) begin
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every counter updates from pre-edge values.
                unique case ({inc_vec[i], dec_vec[i]})
                    2'b10: pend[i] <= pend[i] + PEND_ONE;
                    2'b01: begin
                        if (pend[i] != '0) begin
                            pend[i] <= pend[i] - PEND_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back end of the pipeline: 32-entry integer register file, two read ports, pending-write stall.
// Build option WB_BYPASS_EN forwards the write-back value to the read ports in the same cycle.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [REG_ADDRWIDTH-1:0] wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     rs1_en,
    input  logic [REG_ADDRWIDTH-1:0] rs1_addr,
    input  logic                     rs2_en,
    input  logic [REG_ADDRWIDTH-1:0] rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    input  logic                     issue_en,
    input  logic [REG_ADDRWIDTH-1:0] issue_rd_addr,
    input  logic                     flush,
    output logic                     stall_req
);

    logic [XLEN-1:0] regs [REG_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            // NOTE: the array is flops, not RAM, and its all-zero reset state is architecturally visible.
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= ZERO_32BIT;
            end
        end else if (wb_en && (wb_addr != X0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // x0 is forced last so neither the array nor the bypass can ever leak through it.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (BYPASS_ON && wb_en && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
        if (BYPASS_ON && wb_en && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
        if (rs1_addr == X0) begin
            rs1_data = '0;
        end
        if (rs2_addr == X0) begin
            rs2_data = '0;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .issue_en      (issue_en),
        .issue_rd_addr (issue_rd_addr),
        .rs1_en        (rs1_en),
        .rs1_addr      (rs1_addr),
        .rs2_en        (rs2_en),
        .rs2_addr      (rs2_addr),
        .stall_req     (stall_req)
    );

endmodule
